// File: rtl/steering_pwm_gen_if.sv
// Steering angle stream interface (valid/ready handshake).
//   angle_valid : source has an angle on angle_data
//   angle_data  : signed steering angle, LSB = 0.1 deg
//   angle_ready : sink can take an angle this cycle
// master = angle source (upstream angle calculator), slave = steering_pwm_gen.
interface steering_pwm_gen_if #(
  parameter int ANGLE_W = 16
);
  logic               angle_valid;
  logic [ANGLE_W-1:0] angle_data;
  logic               angle_ready;

  modport master (output angle_valid, output angle_data, input angle_ready);
  modport slave  (input angle_valid, input angle_data, output angle_ready);
endinterface

// File: rtl/steering_pwm_gen.sv
// steering_pwm_gen: converts signed steering angles into a servo PWM signal.
// Pulse width = CENTER_CYCLES + angle*CYCLES_PER_LSB, clamped to [MIN_CYCLES, MAX_CYCLES].
// A one-entry slot holds the newest accepted width; it is moved into pulse_width only on
// the last cycle of a frame so a pulse is never altered while it is being generated.
// Optional build macro STEER_SLEW_LIMIT_EN: pulse_width moves toward the latched target by
// at most SLEW_STEP per frame instead of jumping.
// Ports:
//   ACLK, ARESET  clock, asynchronous active-high reset
//   en            output enable (0 holds the frame counter at 0 and pwm_out low)
//   angle_if      slave side of the angle valid/ready stream
//   pwm_out       servo PWM (registered)
//   pulse_width   width in use in the current frame, in ACLK cycles
//   frame_start   1-cycle pulse aligned with the first pwm_out cycle of each frame
//   clamped       last accepted angle was clamped to MIN/MAX
module steering_pwm_gen #(
  parameter int ANGLE_W        = 16,
  parameter int PERIOD_CYCLES  = 1000000,
  parameter int CENTER_CYCLES  = 75000,
  parameter int CYCLES_PER_LSB = 50,
  parameter int MIN_CYCLES     = 50000,
  parameter int MAX_CYCLES     = 100000,
  parameter int SLEW_STEP      = 500
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              en,
  steering_pwm_gen_if.slave angle_if,
  output logic              pwm_out,
  output logic [19:0]       pulse_width,
  output logic              frame_start,
  output logic              clamped
);
  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic signed [31:0] CTR_S = 32'(CENTER_CYCLES);
  localparam logic signed [31:0] LSB_S = 32'(CYCLES_PER_LSB);
  localparam logic signed [31:0] MIN_S = 32'(MIN_CYCLES);
  localparam logic signed [31:0] MAX_S = 32'(MAX_CYCLES);
  localparam logic [19:0] CENTER_W = 20'(CENTER_CYCLES);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [CNT_W-1:0]   cnt;
  logic [0:0]         slot_st;
  logic [19:0]        slot_q;
  logic               boundary, accept, slot_full;
  logic signed [31:0] ang_ext, raw;
  logic [19:0]        tgt;
  logic               tgt_clamped;

  // Boundary is the last cycle of a running frame; with en low the counter sits at 0.
  assign boundary             = en && (cnt == CNT_LAST);
  assign slot_full            = (slot_st == S_FULL);
  assign angle_if.angle_ready = !slot_full;
  assign accept               = angle_if.angle_valid && !slot_full;

  // Width target for the incoming angle, evaluated in 32-bit signed so large angles
  // cannot wrap before the clamp.
  always_comb begin
    ang_ext     = {{(32-ANGLE_W){angle_if.angle_data[ANGLE_W-1]}}, angle_if.angle_data};
    raw         = CTR_S + ang_ext * LSB_S;
    tgt         = 20'(raw);
    tgt_clamped = 1'b0;
    if (raw < MIN_S) begin
      tgt         = 20'(MIN_CYCLES);
      tgt_clamped = 1'b1;
    end else if (raw > MAX_S) begin
      tgt         = 20'(MAX_CYCLES);
      tgt_clamped = 1'b1;
    end
  end

  // Frame counter and registered outputs; pwm_out and frame_start lag cnt by one
  // cycle, so frame_start marks the cycle where pwm_out reflects count 0.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt         <= '0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (!en || cnt == CNT_LAST) cnt <= '0;
      else                        cnt <= cnt + CNT_W'(1);
      frame_start <= en && (cnt == '0);
      pwm_out     <= en && (32'(cnt) < 32'(pulse_width));
    end
  end

  // Slot FSM: accept only while empty, free only at a boundary, so the two never collide.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      slot_st <= S_EMPTY;
      slot_q  <= CENTER_W;
      clamped <= 1'b0;
    end else if (accept) begin
      slot_st <= S_FULL;
      slot_q  <= tgt;
      clamped <= tgt_clamped;
    end else if (boundary && slot_full) begin
      slot_st <= S_EMPTY;
    end
  end

`ifdef STEER_SLEW_LIMIT_EN
  localparam logic [19:0] STEP_W = 20'(SLEW_STEP);
  logic [19:0] target_q, goal, pw_next;

  // A pending slot value supersedes the latched target at the boundary that consumes it.
  always_comb begin
    goal = slot_full ? slot_q : target_q;
    if (goal > pulse_width + STEP_W)      pw_next = pulse_width + STEP_W;
    else if (goal + STEP_W < pulse_width) pw_next = pulse_width - STEP_W;
    else                                  pw_next = goal;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      target_q    <= CENTER_W;
      pulse_width <= CENTER_W;
    end else if (boundary) begin
      pulse_width <= pw_next;
      if (slot_full) target_q <= slot_q;
    end
  end
`else
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                      pulse_width <= CENTER_W;
    else if (boundary && slot_full)  pulse_width <= slot_q;
  end
`endif
endmodule
